// File: rtl/vram_cmd_pkg.sv
// rtl/vram_cmd_pkg.sv - opcodes, response codes and FSM encoding shared by the VRAM command block
package vram_cmd_pkg;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] RSP_ACK  = 8'h01;
  localparam logic [7:0] RSP_ERR  = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARGS,
    ST_WR_SETUP,
    ST_WR_STROBE,
    ST_WR_HOLD,
    ST_RD_STROBE,
    ST_RESP
  } state_t;

endpackage

// File: rtl/vram_strobe_timer.sv
// rtl/vram_strobe_timer.sv - down-counter timing the width of a VRAM strobe pulse
// Ports: clock, reset (sync, active-high); start loads the count one cycle
// before the strobe begins; done is high during the last strobe cycle.
module vram_strobe_timer #(
  parameter int CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic done
);

  logic [7:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= 8'd0;
    end else if (start) begin
      cnt <= 8'(CYCLES - 1);
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign done = (cnt == 8'd0);

endmodule

// File: rtl/vram_uart_cmd.sv
// rtl/vram_uart_cmd.sv - UART byte command decoder driving a dual-bank VRAM read/write cycle
// Ports: clock, reset (sync, active-high); rx_data/rx_valid received bytes;
// tx_data/tx_valid/tx_busy response bytes; vrd_n/vawr_n/vbwr_n strobes;
// va14/vaa/vab address; vda_o/vdb_o/vda_i/vdb_i data; vd_tristate/lvl_vd_dir
// pad control; overrun sticky dropped-byte flag.
// Build option: VRAM_CMD_TIMEOUT_EN adds an inter-byte timeout in ARGS.
module vram_uart_cmd
  import vram_cmd_pkg::*;
#(
  parameter int STROBE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 120000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_busy,
  output logic        vrd_n,
  output logic        vawr_n,
  output logic        vbwr_n,
  output logic        va14,
  output logic [13:0] vaa,
  output logic [13:0] vab,
  output logic [7:0]  vda_o,
  output logic [7:0]  vdb_o,
  input  logic [7:0]  vda_i,
  input  logic [7:0]  vdb_i,
  output logic        vd_tristate,
  output logic        lvl_vd_dir,
  output logic        overrun
);

  state_t     state, state_nx;
  logic [1:0] arg_cnt;
  logic       is_wr;
  logic [6:0] addr_hi;
  logic [7:0] addr_lo;
  logic [7:0] arg_a;
  logic [7:0] rsp_q0, rsp_q1;
  logic       rsp_two;
  logic       rsp_idx;
  logic       tx_skip;
  logic       tx_fire;
  logic       args_last;
  logic       timer_start;
  logic       timer_done;
  logic       tmo_hit;

  vram_strobe_timer #(.CYCLES(STROBE_CYCLES)) u_timer (
    .clock (clock),
    .reset (reset),
    .start (timer_start),
    .done  (timer_done)
  );

`ifdef VRAM_CMD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clock) begin
    if (reset || state != ST_ARGS || rx_valid) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign tmo_hit = (state == ST_ARGS) && !rx_valid &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nx    = state;
    timer_start = 1'b0;
    args_last   = 1'b0;
    // After each byte one cycle is skipped so a transmitter that raises
    // busy a cycle late is not mistaken for idle.
    tx_fire     = (state == ST_RESP) && !tx_skip && !tx_busy && !reset;
    case (state)
      ST_IDLE: begin
        if (rx_valid) begin
          state_nx = (rx_data == OP_WRITE || rx_data == OP_READ) ? ST_ARGS : ST_RESP;
        end
      end
      ST_ARGS: begin
        if (rx_valid && arg_cnt == (is_wr ? 2'd3 : 2'd1)) begin
          args_last   = 1'b1;
          state_nx    = is_wr ? ST_WR_SETUP : ST_RD_STROBE;
          timer_start = !is_wr;
        end else if (tmo_hit) begin
          state_nx = ST_IDLE;
        end
      end
      ST_WR_SETUP: begin
        state_nx    = ST_WR_STROBE;
        timer_start = 1'b1;
      end
      ST_WR_STROBE: if (timer_done) state_nx = ST_WR_HOLD;
      ST_WR_HOLD:   state_nx = ST_RESP;
      ST_RD_STROBE: if (timer_done) state_nx = ST_RESP;
      ST_RESP:      if (tx_fire && (rsp_idx || !rsp_two)) state_nx = ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
  end

  assign tx_valid = tx_fire;
  assign tx_data  = rsp_idx ? rsp_q1 : rsp_q0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      arg_cnt     <= 2'd0;
      is_wr       <= 1'b0;
      addr_hi     <= 7'd0;
      addr_lo     <= 8'd0;
      arg_a       <= 8'd0;
      rsp_q0      <= 8'd0;
      rsp_q1      <= 8'd0;
      rsp_two     <= 1'b0;
      rsp_idx     <= 1'b0;
      tx_skip     <= 1'b0;
      vrd_n       <= 1'b1;
      vawr_n      <= 1'b1;
      vbwr_n      <= 1'b1;
      vd_tristate <= 1'b1;
      lvl_vd_dir  <= 1'b0;
      overrun     <= 1'b0;
      va14        <= 1'b0;
      vaa         <= 14'd0;
      vab         <= 14'd0;
      vda_o       <= 8'd0;
      vdb_o       <= 8'd0;
    end else begin
      state <= state_nx;

      // Pad controls are registered from the next state so they switch
      // exactly with the state and never glitch on the VRAM pins.
      vrd_n       <= (state_nx != ST_RD_STROBE);
      vawr_n      <= (state_nx != ST_WR_STROBE);
      vbwr_n      <= (state_nx != ST_WR_STROBE);
      vd_tristate <= !(state_nx inside {ST_WR_SETUP, ST_WR_STROBE, ST_WR_HOLD});
      lvl_vd_dir  <=  (state_nx inside {ST_WR_SETUP, ST_WR_STROBE, ST_WR_HOLD});

      if (rx_valid && state != ST_IDLE && state != ST_ARGS) overrun <= 1'b1;

      if (state == ST_IDLE && rx_valid) begin
        is_wr   <= (rx_data == OP_WRITE);
        arg_cnt <= 2'd0;
        rsp_q0  <= RSP_ERR;
        rsp_two <= 1'b0;
      end

      if (state == ST_ARGS && rx_valid) begin
        arg_cnt <= arg_cnt + 2'd1;
        case (arg_cnt)
          2'd0:    addr_hi <= rx_data[6:0];
          2'd1:    addr_lo <= rx_data;
          2'd2:    arg_a   <= rx_data;
          default: ;
        endcase
      end

      // The final argument byte is still on rx_data, so it is used directly.
      if (args_last) begin
        va14 <= addr_hi[6];
        if (is_wr) begin
          vaa   <= {addr_hi[5:0], addr_lo};
          vab   <= {addr_hi[5:0], addr_lo};
          vda_o <= arg_a;
          vdb_o <= rx_data;
        end else begin
          vaa <= {addr_hi[5:0], rx_data};
          vab <= {addr_hi[5:0], rx_data};
        end
      end

      if (state == ST_WR_HOLD) begin
        rsp_q0  <= RSP_ACK;
        rsp_two <= 1'b0;
      end

      if (state == ST_RD_STROBE && timer_done) begin
        rsp_q0  <= vda_i;
        rsp_q1  <= vdb_i;
        rsp_two <= 1'b1;
      end

      if (state != ST_RESP) begin
        rsp_idx <= 1'b0;
      end else if (tx_fire) begin
        rsp_idx <= 1'b1;
      end
      tx_skip <= tx_fire;
    end
  end

endmodule

// File: tb/tb_vram_uart_cmd.sv
// tb/tb_vram_uart_cmd.sv - self-checking bench for vram_uart_cmd with VRAM and UART models
module tb_vram_uart_cmd;

  localparam int TMO = 200;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_busy = 1'b0;
  logic        vrd_n, vawr_n, vbwr_n, va14;
  logic [13:0] vaa, vab;
  logic [7:0]  vda_o, vdb_o, vda_i, vdb_i;
  logic        vd_tristate, lvl_vd_dir, overrun;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem_a [0:32767];
  logic [7:0] mem_b [0:32767];
  logic [7:0] exp_a [0:32767];
  logic [7:0] exp_b [0:32767];
  logic [7:0] tx_q [$];
  logic [14:0] written [$];

  int wr_run = 0, rd_run = 0, last_wr_w = 0, last_rd_w = 0;
  int wr_pulses = 0, rd_pulses = 0, conflicts = 0, rd_drive = 0, tx_viol = 0;

  always #5 clock = ~clock;

  assign vda_i = mem_a[{va14, vaa}];
  assign vdb_i = mem_b[{va14, vab}];

  vram_uart_cmd #(.STROBE_CYCLES(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
    .vrd_n(vrd_n), .vawr_n(vawr_n), .vbwr_n(vbwr_n), .va14(va14),
    .vaa(vaa), .vab(vab), .vda_o(vda_o), .vdb_o(vdb_o),
    .vda_i(vda_i), .vdb_i(vdb_i), .vd_tristate(vd_tristate),
    .lvl_vd_dir(lvl_vd_dir), .overrun(overrun)
  );

  // VRAM model and bus monitor: memory writes land while the write strobe
  // is low; pulse widths and illegal bus combinations are recorded.
  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem_a[i] = 8'd0;
      mem_b[i] = 8'd0;
    end
    forever begin
      @(negedge clock);
      if ((!vawr_n || !vbwr_n) && !vrd_n) conflicts++;
      if (vawr_n !== vbwr_n) conflicts++;
      if (!vawr_n && (vd_tristate || !lvl_vd_dir)) conflicts++;
      if (vd_tristate === lvl_vd_dir) conflicts++;
      if (!vrd_n && !vd_tristate) rd_drive++;
      if (!vawr_n) begin
        mem_a[{va14, vaa}] = vda_o;
        mem_b[{va14, vab}] = vdb_o;
        wr_run++;
      end else if (wr_run > 0) begin
        last_wr_w = wr_run;
        wr_pulses++;
        wr_run = 0;
      end
      if (!vrd_n) begin
        rd_run++;
      end else if (rd_run > 0) begin
        last_rd_w = rd_run;
        rd_pulses++;
        rd_run = 0;
      end
    end
  end

  // UART transmitter model: random busy time after each accepted byte.
  initial begin
    automatic int busy_left = 0;
    automatic bit fired;
    forever begin
      @(negedge clock);
      fired = (tx_valid === 1'b1);
      if (fired) begin
        tx_q.push_back(tx_data);
        if (tx_busy) tx_viol++;
      end
      @(posedge clock);
      #1;
      if (fired) busy_left = $urandom_range(0, 4);
      else if (busy_left > 0) busy_left--;
      tx_busy = (busy_left != 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clock);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] b0, b1, b2, b3, b4, input int n);
    logic [7:0] bs [5];
    bs = '{b0, b1, b2, b3, b4};
    for (int i = 0; i < n; i++) send_byte(bs[i]);
  endtask

  task automatic wait_tx(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      if (tx_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_wr_low(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (!vawr_n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [15:0] got [12];
    logic [15:0] want [12];
    string nm [12];
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    got  = '{16'(vrd_n), 16'(vawr_n), 16'(vbwr_n), 16'(vd_tristate), 16'(lvl_vd_dir),
             16'(tx_valid), 16'(overrun), 16'(va14), 16'(vaa), 16'(vab), 16'(vda_o), 16'(vdb_o)};
    want = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    nm   = '{"vrd_n", "vawr_n", "vbwr_n", "vd_tristate", "lvl_vd_dir", "tx_valid",
             "overrun", "va14", "vaa", "vab", "vda_o", "vdb_o"};
    for (int i = 0; i < 12; i++) begin
      vectors++;
      if (got[i] !== want[i]) begin
        miscompares++;
        $display("FAIL reset_%s got %h want %h", nm[i], got[i], want[i]);
      end
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_write();
    bit ok;
    int w0 = wr_pulses;
    tx_q.delete();
    send_cmd(8'h01, 8'h7F, 8'hFF, 8'hA1, 8'hB2, 5);
    wait_tx(1, ok);
    exp_a[15'h7FFF] = 8'hA1;
    exp_b[15'h7FFF] = 8'hB2;
    written.push_back(15'h7FFF);
    vectors++; if (!ok) begin miscompares++; $display("FAIL write_ack_wait got timeout want 1 byte"); end
    vectors++; if (tx_q[0] !== 8'h01) begin miscompares++; $display("FAIL write_ack got %h want 01", tx_q[0]); end
    vectors++; if (va14 !== 1'b1) begin miscompares++; $display("FAIL write_va14 got %b want 1", va14); end
    vectors++; if (vaa !== 14'h3FFF) begin miscompares++; $display("FAIL write_vaa got %h want 3fff", vaa); end
    vectors++; if (vab !== 14'h3FFF) begin miscompares++; $display("FAIL write_vab got %h want 3fff", vab); end
    vectors++; if (vda_o !== 8'hA1) begin miscompares++; $display("FAIL write_vda_o got %h want a1", vda_o); end
    vectors++; if (vdb_o !== 8'hB2) begin miscompares++; $display("FAIL write_vdb_o got %h want b2", vdb_o); end
    vectors++; if (last_wr_w !== 4) begin miscompares++; $display("FAIL write_width got %0d want 4", last_wr_w); end
    vectors++; if (wr_pulses !== w0 + 1) begin miscompares++; $display("FAIL write_pulses got %0d want %0d", wr_pulses, w0 + 1); end
    vectors++; if (mem_a[15'h7FFF] !== 8'hA1 || mem_b[15'h7FFF] !== 8'hB2) begin
      miscompares++; $display("FAIL write_mem got %h%h want a1b2", mem_a[15'h7FFF], mem_b[15'h7FFF]);
    end
    vectors++; if (vd_tristate !== 1'b1 || lvl_vd_dir !== 1'b0) begin
      miscompares++; $display("FAIL write_release got tri=%b dir=%b want tri=1 dir=0", vd_tristate, lvl_vd_dir);
    end
  endtask

  task automatic test_read();
    bit ok;
    int r0, w0, d0;
    tx_q.delete();
    send_cmd(8'h01, 8'h00, 8'h10, 8'h5A, 8'hC3, 5);
    wait_tx(1, ok);
    exp_a[15'h0010] = 8'h5A;
    exp_b[15'h0010] = 8'hC3;
    written.push_back(15'h0010);
    repeat (2) @(posedge clock);
    r0 = rd_pulses; w0 = wr_pulses; d0 = rd_drive;
    tx_q.delete();
    send_cmd(8'h02, 8'h00, 8'h10, 8'h00, 8'h00, 3);
    wait_tx(2, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL read_wait got timeout want 2 bytes"); end
    vectors++; if (tx_q[0] !== exp_a[15'h0010]) begin miscompares++; $display("FAIL read_byte_a got %h want 5a", tx_q[0]); end
    vectors++; if (tx_q[1] !== exp_b[15'h0010]) begin miscompares++; $display("FAIL read_byte_b got %h want c3", tx_q[1]); end
    vectors++; if (last_rd_w !== 4) begin miscompares++; $display("FAIL read_width got %0d want 4", last_rd_w); end
    vectors++; if (rd_pulses !== r0 + 1) begin miscompares++; $display("FAIL read_pulses got %0d want %0d", rd_pulses, r0 + 1); end
    vectors++; if (wr_pulses !== w0) begin miscompares++; $display("FAIL read_no_write got %0d want %0d", wr_pulses, w0); end
    vectors++; if (rd_drive !== d0) begin miscompares++; $display("FAIL read_tristate got %0d driven cycles want 0", rd_drive - d0); end
    vectors++; if (va14 !== 1'b0 || vaa !== 14'h0010) begin
      miscompares++; $display("FAIL read_addr got %b/%h want 0/0010", va14, vaa);
    end
  endtask

  task automatic test_bad_opcode();
    bit ok;
    int r0 = rd_pulses, w0 = wr_pulses;
    repeat (2) @(posedge clock);
    tx_q.delete();
    send_byte(8'h33);
    wait_tx(1, ok);
    repeat (20) @(posedge clock);
    vectors++; if (!ok) begin miscompares++; $display("FAIL badop_wait got timeout want 1 byte"); end
    vectors++; if (tx_q[0] !== 8'hEE) begin miscompares++; $display("FAIL badop_resp got %h want ee", tx_q[0]); end
    vectors++; if (tx_q.size() !== 1) begin miscompares++; $display("FAIL badop_count got %0d want 1", tx_q.size()); end
    vectors++; if (rd_pulses !== r0 || wr_pulses !== w0) begin
      miscompares++; $display("FAIL badop_strobes got rd=%0d wr=%0d want rd=%0d wr=%0d", rd_pulses, wr_pulses, r0, w0);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    tx_q.delete();
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL overrun_initial got %b want 0", overrun); end
    send_cmd(8'h01, 8'h12, 8'h34, 8'h55, 8'h66, 5);
    wait_wr_low(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL overrun_strobe_wait got timeout want strobe"); end
    send_byte(8'h02);
    wait_tx(1, ok);
    exp_a[15'h1234] = 8'h55;
    exp_b[15'h1234] = 8'h66;
    written.push_back(15'h1234);
    repeat (30) @(posedge clock);
    vectors++; if (tx_q[0] !== 8'h01) begin miscompares++; $display("FAIL overrun_ack got %h want 01", tx_q[0]); end
    vectors++; if (tx_q.size() !== 1) begin miscompares++; $display("FAIL overrun_extra got %0d bytes want 1", tx_q.size()); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_flag got %b want 1", overrun); end
    vectors++; if (last_wr_w !== 4) begin miscompares++; $display("FAIL overrun_width got %0d want 4", last_wr_w); end
    vectors++; if (mem_a[15'h1234] !== 8'h55 || mem_b[15'h1234] !== 8'h66) begin
      miscompares++; $display("FAIL overrun_mem got %h%h want 5566", mem_a[15'h1234], mem_b[15'h1234]);
    end
  endtask

  task automatic test_reset_mid_strobe();
    bit ok;
    int w0 = wr_pulses;
    tx_q.delete();
    send_cmd(8'h01, 8'h00, 8'h05, 8'h11, 8'h22, 5);
    wait_wr_low(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rstmid_strobe_wait got timeout want strobe"); end
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    vectors++; if (vawr_n !== 1'b1 || vbwr_n !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_strobe got %b%b want 11", vawr_n, vbwr_n);
    end
    vectors++; if (vd_tristate !== 1'b1 || lvl_vd_dir !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_pads got tri=%b dir=%b want tri=1 dir=0", vd_tristate, lvl_vd_dir);
    end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL rstmid_overrun got %b want 0", overrun); end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    exp_a[15'h0005] = 8'h11;
    exp_b[15'h0005] = 8'h22;
    repeat (40) @(posedge clock);
    @(negedge clock);
    vectors++; if (last_wr_w !== 2) begin miscompares++; $display("FAIL rstmid_width got %0d want 2", last_wr_w); end
    vectors++; if (wr_pulses !== w0 + 1) begin miscompares++; $display("FAIL rstmid_pulses got %0d want %0d", wr_pulses, w0 + 1); end
    vectors++; if (tx_q.size() !== 0) begin miscompares++; $display("FAIL rstmid_no_tx got %0d bytes want 0", tx_q.size()); end
  endtask

  task automatic test_random();
    bit ok;
    int sel;
    logic [14:0] a;
    logic hb;
    logic [7:0] da, db, op;
    for (int k = 0; k < 30; k++) begin
      sel = $urandom_range(0, 9);
      a   = 15'($urandom);
      hb  = 1'($urandom);
      da  = 8'($urandom);
      db  = 8'($urandom);
      tx_q.delete();
      if (sel == 0) begin
        op = 8'($urandom_range(3, 255));
        send_byte(op);
        wait_tx(1, ok);
        vectors++; if (!ok || tx_q[0] !== 8'hEE) begin
          miscompares++; $display("FAIL rand_badop op=%h got %h want ee", op, tx_q[0]);
        end
      end else if (sel <= 5) begin
        send_cmd(8'h01, {hb, a[14:8]}, a[7:0], da, db, 5);
        wait_tx(1, ok);
        exp_a[a] = da;
        exp_b[a] = db;
        written.push_back(a);
        vectors++; if (!ok || tx_q[0] !== 8'h01) begin
          miscompares++; $display("FAIL rand_write_ack addr=%h got %h want 01", a, tx_q[0]);
        end
        vectors++; if (va14 !== a[14] || vaa !== a[13:0] || vab !== a[13:0]) begin
          miscompares++; $display("FAIL rand_write_addr got %b/%h/%h want %b/%h", va14, vaa, vab, a[14], a[13:0]);
        end
        vectors++; if (vda_o !== da || vdb_o !== db) begin
          miscompares++; $display("FAIL rand_write_data got %h%h want %h%h", vda_o, vdb_o, da, db);
        end
      end else begin
        if (written.size() > 0 && $urandom_range(0, 1) == 1)
          a = written[$urandom_range(0, written.size() - 1)];
        send_cmd(8'h02, {hb, a[14:8]}, a[7:0], 8'h00, 8'h00, 3);
        wait_tx(2, ok);
        vectors++; if (!ok || tx_q[0] !== exp_a[a] || tx_q[1] !== exp_b[a]) begin
          miscompares++; $display("FAIL rand_read addr=%h got %h%h want %h%h", a, tx_q[0], tx_q[1], exp_a[a], exp_b[a]);
        end
      end
      repeat ($urandom_range(0, 3)) @(posedge clock);
    end
  endtask

`ifdef VRAM_CMD_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    repeat (4) @(posedge clock);
    tx_q.delete();
    send_cmd(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 2);
    repeat (TMO + 1) @(posedge clock);
    send_cmd(8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 3);
    wait_tx(2, ok);
    repeat (10) @(posedge clock);
    vectors++; if (!ok || tx_q[0] !== exp_a[0] || tx_q[1] !== exp_b[0]) begin
      miscompares++; $display("FAIL timeout_read got %h%h want %h%h", tx_q[0], tx_q[1], exp_a[0], exp_b[0]);
    end
    vectors++; if (tx_q.size() !== 2) begin miscompares++; $display("FAIL timeout_count got %0d want 2", tx_q.size()); end
  endtask
`endif

  task automatic test_invariants();
    vectors++; if (conflicts !== 0) begin miscompares++; $display("FAIL bus_conflicts got %0d want 0", conflicts); end
    vectors++; if (rd_drive !== 0) begin miscompares++; $display("FAIL read_drive got %0d want 0", rd_drive); end
    vectors++; if (tx_viol !== 0) begin miscompares++; $display("FAIL tx_while_busy got %0d want 0", tx_viol); end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      exp_a[i] = 8'd0;
      exp_b[i] = 8'd0;
    end
    test_reset();
    test_write();
    test_read();
    test_bad_opcode();
    test_overrun();
    test_reset_mid_strobe();
    test_random();
`ifdef VRAM_CMD_TIMEOUT_EN
    test_timeout();
`endif
    test_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
